// File: rtl/sqrt2_pwl_eval.sv
// sqrt2_pwl_eval
// Piecewise-linear evaluator for the Sqrt2 stage of the Box-Muller AWGN path.
// It reads one 32-bit word from the 64-entry coefficient table and computes
//    y = C_HI - ((C_LO * offset) >> OFF_W)
// The table address is taken from the top SEG_W bits of the operand, and
// offset is taken from the remaining low bits.
//
// Ports:
//    clk, reset           system clock; synchronous active-high reset
//    in_valid / in_ready  operand handshake; x_in is sampled on accept
//    coeff_addr           registered table address
//    coeff_data           table word: [31:12] C_HI, [11:0] C_LO
//    out_valid/out_ready  result handshake; y_out is held until taken
//    busy                 high whenever the FSM is not idle
//    sat_flag             only with SQRT2_PWL_SAT_EN: sticky clamp indicator
//
// Build option: SQRT2_PWL_SAT_EN clamps negative results to zero and adds
// sat_flag. Without it, the result wraps modulo 2^HI_W.
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// FETCH | table address stable, waiting TABLE_LAT+1 cycles for coeff_data
// MUL   | slope times offset
// SUB   | intercept minus scaled product, result registered
// OUT   | result presented until out_ready
module sqrt2_pwl_eval #(
    parameter int X_W       = 16,
    parameter int SEG_W     = 6,
    parameter int HI_W      = 20,
    parameter int LO_W      = 12,
    parameter int TABLE_LAT = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [X_W-1:0]    x_in,
    output logic [SEG_W-1:0]  coeff_addr,
    input  logic [31:0]       coeff_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [HI_W-1:0]   y_out,
    output logic              busy
`ifdef SQRT2_PWL_SAT_EN
    ,
    output logic              sat_flag
`endif
);

    localparam int OFF_W = X_W - SEG_W;
    localparam int P_W   = LO_W + OFF_W;
    localparam int CNT_W = (TABLE_LAT > 0) ? $clog2(TABLE_LAT + 1) : 1;

    typedef enum logic [2:0] {IDLE, FETCH, MUL, SUB, OUT} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [OFF_W-1:0]   offset;
    logic [HI_W-1:0]    c_hi;
    logic [LO_W-1:0]    c_lo;
    logic [P_W-1:0]     prod;

`ifdef SQRT2_PWL_SAT_EN
    logic [HI_W:0]      diff;
    assign diff = {1'b0, c_hi} - (HI_W+1)'(prod >> OFF_W);
`else
    // Only the low HI_W bits are kept, so the borrow bit is not computed.
    logic [HI_W-1:0]    diff;
    assign diff = c_hi - HI_W'(prod >> OFF_W);
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                in_ready = ~reset;
                if (in_valid) state_nxt = FETCH;
            end
            FETCH:   if (cnt == '0) state_nxt = MUL;
            MUL:     state_nxt = SUB;
            SUB:     state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            offset     <= '0;
            c_hi       <= '0;
            c_lo       <= '0;
            prod       <= '0;
            coeff_addr <= '0;
            y_out      <= '0;
            out_valid  <= 1'b0;
`ifdef SQRT2_PWL_SAT_EN
            sat_flag   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    offset     <= x_in[OFF_W-1:0];
                    coeff_addr <= x_in[X_W-1:OFF_W];
                    cnt        <= CNT_W'(TABLE_LAT);
                end
                FETCH: begin
                    // Data is sampled only on the last wait cycle so that a
                    // pipelined table has had time to settle.
                    if (cnt == '0) begin
                        c_hi <= coeff_data[31:32-HI_W];
                        c_lo <= coeff_data[LO_W-1:0];
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                MUL: prod <= {{OFF_W{1'b0}}, c_lo} * {{LO_W{1'b0}}, offset};
                SUB: begin
`ifdef SQRT2_PWL_SAT_EN
                    if (diff[HI_W]) begin
                        y_out    <= '0;
                        sat_flag <= 1'b1;
                    end else begin
                        y_out <= diff[HI_W-1:0];
                    end
`else
                    y_out <= diff;
`endif
                    out_valid <= 1'b1;
                end
                OUT: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sqrt2_pwl_eval.sv
module tb_sqrt2_pwl_eval;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [15:0] x_in;
    logic [5:0]  coeff_addr;
    logic [31:0] coeff_data;
    logic [19:0] y_out;

    logic        in_valid2, in_ready2, out_valid2, out_ready2, busy2;
    logic [15:0] x_in2;
    logic [5:0]  coeff_addr2, addr_d1, addr_d2;
    logic [31:0] coeff_data2;
    logic [19:0] y_out2;
`ifdef SQRT2_PWL_SAT_EN
    logic        sat_flag, sat_flag2;
`endif

    sqrt2_pwl_eval dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .x_in(x_in), .coeff_addr(coeff_addr), .coeff_data(coeff_data),
        .out_valid(out_valid), .out_ready(out_ready), .y_out(y_out), .busy(busy)
`ifdef SQRT2_PWL_SAT_EN
        , .sat_flag(sat_flag)
`endif
    );

    sqrt2_pwl_eval #(.TABLE_LAT(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
        .x_in(x_in2), .coeff_addr(coeff_addr2), .coeff_data(coeff_data2),
        .out_valid(out_valid2), .out_ready(out_ready2), .y_out(y_out2), .busy(busy2)
`ifdef SQRT2_PWL_SAT_EN
        , .sat_flag(sat_flag2)
`endif
    );

    function automatic logic [31:0] tbl(input logic [5:0] a);
        case (a)
            6'd0:    return {20'd1020, 12'd1024};
            6'd1:    return {20'd1012, 12'd1530};
            6'd63:   return {20'd725, 12'd1410};
            default: return {20'd1000 - 20'(a) * 20'd4, 12'd1400};
        endcase
    endfunction

    assign coeff_data = tbl(coeff_addr);

    // the second table needs two cycles from address to data
    always @(posedge clk) begin
        addr_d1 <= coeff_addr2;
        addr_d2 <= addr_d1;
    end
    assign coeff_data2 = tbl(addr_d2);

    function automatic logic [19:0] model(input logic [15:0] x);
        logic [31:0] c;
        logic [21:0] p;
        logic [20:0] d;
        c = tbl(x[15:10]);
        p = 22'(c[11:0]) * 22'(x[9:0]);
        d = {1'b0, c[31:12]} - 21'(p >> 10);
`ifdef SQRT2_PWL_SAT_EN
        return d[20] ? 20'd0 : d[19:0];
`else
        return d[19:0];
`endif
    endfunction

    typedef struct {
        logic [19:0] y;
        int          acc;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    logic ov_q = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (out_valid && !ov_q) begin
            if (sb.size() == 0) begin
                chk("spurious_out_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("y_out", y_out, e.y);
                chk("latency", cyc - e.acc, 3);
            end
        end
        ov_q = out_valid;
    end

    task automatic send(input logic [15:0] x, input logic [19:0] ye, output int acc);
        exp_t e;
        x_in = x;
        in_valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 40; i++) begin
            if (in_ready) begin
                acc = cyc + 1;
                break;
            end
            @(negedge clk);
        end
        if (acc < 0) begin
            chk("accept_timeout", 0, 1);
        end else begin
            e.y = ye;
            e.acc = acc;
            sb.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
        if (acc >= 0) chk("coeff_addr", coeff_addr, x[15:10]);
    endtask

    task automatic drain();
        int ok;
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            if (sb.size() == 0 && !out_valid) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (ok == 0) chk("drain_timeout", 0, 1);
    endtask

    initial begin
        int a0, a1, got;
        logic [15:0] x;
        reset = 1'b1; in_valid = 1'b0; x_in = '0; out_ready = 1'b1;
        in_valid2 = 1'b0; x_in2 = '0; out_ready2 = 1'b1;
        repeat (3) @(negedge clk);
        chk("in_ready_during_reset", in_ready, 0);
        reset = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_y_out", y_out, 0);
        chk("rst_coeff_addr", coeff_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);

        send(16'h0000, 20'd1020, a0); drain();
        send(16'h0600, 20'd247, a0);  drain();
        send(16'hFE00, 20'd20, a0);   drain();
`ifdef SQRT2_PWL_SAT_EN
        send(16'h03FF, 20'd0, a0);    drain();
        chk("sat_flag", sat_flag, 1);
`else
        send(16'h03FF, 20'd1048573, a0); drain();
`endif

        send(16'h1234, model(16'h1234), a0);
        send(16'h8765, model(16'h8765), a1);
        chk("issue_interval", a1 - a0, 5);
        drain();

        for (int i = 0; i < 6; i++) begin
            x = 16'($urandom);
            send(x, model(x), a0);
        end
        drain();

        // output held back: result stable, new operands ignored
        out_ready = 1'b0;
        send(16'h0600, 20'd247, a0);
        got = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        chk("hold_out_valid_seen", got, 1);
        for (int i = 0; i < 10; i++) begin
            in_valid = (i % 2 == 0);
            x_in = 16'hFC00;
            @(negedge clk);
            chk("hold_y", y_out, 247);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_out_valid", out_valid, 1);
        end
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("release_in_ready", in_ready, 1);
        chk("release_out_valid", out_valid, 0);
        chk("no_accept_on_handshake", coeff_addr, 1);
        chk("release_busy", busy, 0);

        // abort in MUL, with in_valid during reset
        send(16'h0600, 20'd247, a0);
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b1;
        x_in = 16'hFE00;
        @(negedge clk);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_y_out", y_out, 0);
        chk("abort_coeff_addr", coeff_addr, 0);
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 0);
`ifdef SQRT2_PWL_SAT_EN
        chk("abort_sat_flag", sat_flag, 0);
`endif
        sb.delete();
        reset = 1'b0;
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("abort_no_out", out_valid, 0);
        chk("abort_idle", busy, 0);

        // two-cycle table latency
        x_in2 = 16'hFE00;
        in_valid2 = 1'b1;
        chk("lat2_in_ready", in_ready2, 1);
        a0 = cyc + 1;
        @(negedge clk);
        in_valid2 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("lat2_addr_stable", coeff_addr2, 63);
            @(negedge clk);
        end
        got = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid2) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        chk("lat2_out_seen", got, 1);
        chk("lat2_latency", cyc - a0, 5);
        chk("lat2_y", y_out2, 20);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sqrt2_pwl_eval.md
Name: sqrt2_pwl_eval

Overview:
- Consumer (reader) of the 64-entry Sqrt2 coefficient table in the Box-Muller AWGN datapath.
- Accepts an unsigned fixed-point operand and drives the 6-bit table address from its top bits.
- Samples the 32-bit coefficient word and evaluates the piecewise-linear approximation y = C_HI - ((C_LO * offset) >> OFF_W).
- Returns the result through a valid/ready handshake; sits between the uniform-to-log stage and the Box-Muller multiplier.

Parameters:
- X_W, 16: operand width.
- SEG_W, 6: segment index width; table depth is 2^SEG_W.
- HI_W, 20: intercept field width, coeff_data[31:12].
- LO_W, 12: slope field width, coeff_data[11:0].
- TABLE_LAT, 0: extra clock cycles the table needs between address change and valid data (0 = combinational table).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand valid.
- in_ready  output  1  block can accept an operand.
- x_in  input  X_W  unsigned operand.
- coeff_addr  output  SEG_W  table address, registered.
- coeff_data  input  32  table word: [31:12] C_HI, [11:0] C_LO, both unsigned.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- y_out  output  HI_W  result, registered.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- One clock; reset synchronous, active-high. Clock port is clk, reset port is reset.
- Derived widths: OFF_W = X_W - SEG_W (10 by default); product width LO_W + OFF_W (22 by default).
- Reset values: out_valid=0, y_out=0, coeff_addr=0, busy=0, state=IDLE. in_ready = (state==IDLE) & ~reset, so it reads 0 during reset and 1 in the first cycle after reset.
- FSM states: IDLE, FETCH, MUL, SUB, OUT.
- IDLE: in_ready=1. On in_valid at a clock edge (accept edge A):
  - capture offset = x_in[OFF_W-1:0];
  - load coeff_addr <= x_in[X_W-1:OFF_W];
  - go to FETCH and load a wait counter with TABLE_LAT.
- FETCH: lasts TABLE_LAT+1 cycles; coeff_addr held constant.
  - On the last FETCH cycle, latch C_HI and C_LO from coeff_data, then go to MUL.
  - The counter decrements each FETCH cycle; it is a plain down-counter with no wrap.
- MUL: prod <= C_LO * offset, unsigned, full width. Go to SUB.
- SUB: diff = {1'b0,C_HI} - (prod >> OFF_W), computed in HI_W+1 bits. y_out <= diff[HI_W-1:0] (see Optional Feature). Set out_valid=1 and go to OUT.
- Latency: out_valid first high TABLE_LAT+3 cycles after edge A (3 with default parameters).
- OUT: out_valid and y_out are held stable until out_ready=1.
  - On the out_valid & out_ready edge: out_valid <= 0, go to IDLE.
  - in_ready rises the following cycle.
  - No new operand is accepted in the same cycle as the output handshake.
  - Minimum issue interval is TABLE_LAT+5 cycles.
- in_valid while not IDLE is ignored; x_in is not sampled.
- coeff_addr keeps its last value after the operation ends; it changes only on an accept edge or on reset.
- Reset mid-operation (any state): the operation is aborted and the result discarded. All outputs return to reset values on the next edge, and no out_valid pulse is produced for the aborted operand.
- Boundaries:
  - offset=0 gives y_out=C_HI exactly.
  - addr=2^SEG_W-1 (the last segment) is handled with no special case.
  - Simultaneous reset and in_valid: reset wins and nothing is accepted.

Optional Feature:
- Macro: SQRT2_PWL_SAT_EN.
- Defined: if diff is negative (diff[HI_W]=1), y_out <= 0. A sticky output sat_flag (1 bit, reset 0) is added; it sets on any clamp and clears only on reset.
- Undefined: y_out <= diff[HI_W-1:0], i.e. modulo-2^HI_W wrap. No sat_flag port exists.

Test Plan:
- Reset, then idle. Expected: out_valid=0, y_out=0, coeff_addr=0, busy=0; in_ready=1 on the first post-reset cycle.
- x_in=0x0000, table entry 0 = C_HI 1020 / C_LO 1024, out_ready=1. Expected: coeff_addr=0; out_valid exactly 3 cycles after accept; y_out=1020.
- x_in=0x0600, entry 1 = 1012/1530. Expected: coeff_addr=1; prod>>10 = 765; y_out=247.
- x_in=0xFE00, entry 63 = 725/1410. Expected: coeff_addr=63; y_out=20.
  - Repeat with TABLE_LAT=2: latency is 5 cycles, and coeff_addr is stable through all 3 FETCH cycles.
- x_in=0x03FF, entry 0 = 1020/1024 (1023 subtracted). Expected: y_out=0 and sat_flag=1 with SQRT2_PWL_SAT_EN; y_out=1048573 without it.
- Hold out_ready=0 for 10 cycles: y_out stays stable, in_ready=0, and in_valid pulses are ignored. Then raise out_ready: in_ready returns the next cycle.
  - Separately, assert reset during MUL: no out_valid pulse, and all outputs are at reset values on the next edge.
